rom_rr_arbiter: RTL
===================

ROM_RR_ARBITER -- requirements
Module: rom_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  level request from requester 0 / 1
- addr0 / addr1  in  4  burst start address
- len0 / len1  in  4  burst length minus one (0..15 = 1..16 words)
- gnt0 / gnt1  out  1  one-cycle grant pulse
- busy  out  1  a burst is in progress (state not IDLE)
- rd_data  out  7  read word; combinational pass-through of rom_data
- rd_addr  out  4  address of rd_data; combinational pass-through of rom_addr_in
- rd_valid0 / rd_valid1  out  1  rd_data is valid for requester 0 / 1
- done0 / done1  out  1  one-cycle pulse coinciding with the final rd_valid of a burst
- rom_addr  out  4  registered address to the ROM
- rom_ena  out  1  ROM read enable
- rom_data  in  7  registered ROM data output
- rom_addr_in  in  4  registered ROM address echo

Function
REQ-003 The ROM SHALL be treated as 1-cycle latency: rom_addr/rom_ena sampled at edge N; rom_data and rom_addr_in valid in cycle N+1.
REQ-004 The FSM SHALL have three states: IDLE, ISSUE and DRAIN.
REQ-005 In IDLE with any req high, at the next edge the block SHALL:
- pulse the winner's gnt for one cycle
- latch the winner's addr and len
- enter ISSUE
REQ-006 Arbitration SHALL be round-robin on a last-served pointer:
- single request wins outright
- if both request, the requester not last served wins
- pointer updates at each grant
REQ-007 Arbitration SHALL occur only in IDLE; requests arriving during ISSUE/DRAIN SHALL wait. A requester holds req until its gnt; req SHALL NOT be sampled after grant.
REQ-008 In ISSUE, rom_ena SHALL be 1 with rom_addr = current address; each cycle the address increments modulo 16 (15 -> 0) and the remaining count decrements.
REQ-009 ISSUE SHALL last exactly len+1 cycles, then go to DRAIN.
REQ-010 In DRAIN, rom_ena SHALL be 0; next state SHALL be IDLE.
REQ-011 rd_validX SHALL be a registered copy of (rom_ena AND owner==X), so valids occupy the len+1 cycles following the first ISSUE cycle.
REQ-012 doneX SHALL pulse in the DRAIN cycle (the final rd_validX cycle).
REQ-013 Timing: req seen in IDLE cycle 0 -> gnt in cycle 1 -> valids in cycles 2..len+2 -> done in cycle len+2 -> IDLE in cycle len+3, when a new grant may be issued.
REQ-014 Deasserting req mid-burst SHALL NOT abort the burst.
REQ-015 When rom_ena is 0, rom_addr SHALL hold its last value.
REQ-016 busy SHALL be 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-017 gnt0 and gnt1 SHALL never be high together; rd_valid0 and rd_valid1 SHALL never be high together.

Reset
REQ-018 rst high at a clock edge SHALL take effect on that edge regardless of state, giving:
- state IDLE, last-served pointer = 1 (requester 0 wins the first tie)
- gnt0/1, rd_valid0/1, done0/1, busy, rom_ena = 0; rom_addr = 0
REQ-019 Reset mid-burst SHALL discard the in-flight read: no rd_valid or done in the cycle after reset.
REQ-020 Requests held through reset SHALL be arbitrated normally from the first IDLE cycle after rst falls.

Verification
REQ-021 Single word: req0, addr0=5, len0=0 -> gnt0 in cycle 1; rd_valid0 and done0 in cycle 2 with rd_addr=5; busy=1 in cycles 1-2.
REQ-022 Wrap-around: req1, addr1=14, len1=3 -> rd_addr sequence 14, 15, 0, 1 with rd_valid1 high for exactly 4 cycles; done1 on the word with rd_addr=1.
REQ-023 Tie and fairness: req0 and req1 held from reset release, both len=1 -> gnt0 first, then gnt1 in the first IDLE after done0; next tie grants requester 0 again.
REQ-024 Blocking: req1 asserted during requester 0's 16-word burst (addr0=0, len0=15) -> gnt1 only after done0 plus one IDLE cycle; valids never overlap.
REQ-025 Reset mid-burst: rst high in the third ISSUE cycle of a len=7 burst -> next cycle busy=0, rom_ena=0, rd_valid=0, done=0; then req1 is granted first.
REQ-026 Full sweep: addr0=0, len0=15 -> 16 consecutive valids with rd_addr 0..15; rd_data matches the ROM contents at each address.

Source files
------------

// File: rtl/rom_rr_arbiter.sv
// Two-requester round-robin burst reader in front of a 1-cycle-latency ROM.
//
// Handshake: a requester raises reqX as a level, with addrX/lenX stable,
// and holds it until it sees gntX. The grant is a one-cycle pulse. Read
// data comes back as rd_validX beats, one per ROM word, and doneX marks
// the final beat. Requests are sampled only while the block is idle.
//
// Timeline for a burst of len+1 words:
//   cycle 0        IDLE, req seen
//   cycle 1        gnt pulse, first ISSUE cycle (rom_ena=1, rom_addr=start)
//   cycles 1..len+1  ISSUE, one ROM read per cycle
//   cycles 2..len+2  rd_valid beats (ROM data arrives one cycle after issue)
//   cycle len+2    DRAIN, done pulse with the last beat
//   cycle len+3    IDLE again, next grant may be issued
module rom_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic [6:0] rd_data,
    output logic [3:0] rd_addr,
    output logic       rd_valid0,
    output logic       rd_valid1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] rom_addr,
    output logic       rom_ena,
    input  logic [6:0] rom_data,
    input  logic [3:0] rom_addr_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;     // requester currently being served
    logic       last_q, last_d;       // requester served most recently
    logic [3:0] cnt_q, cnt_d;         // words still to issue after the current one
    logic [3:0] rom_addr_q, rom_addr_d;
    logic       rom_ena_q, rom_ena_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       rd_valid0_q, rd_valid1_q;
    logic       pick1;

    // Round-robin choice: a lone requester wins; on a tie the one not
    // served last wins.
    always_comb begin
        pick1 = req1 & (~req0 | ~last_q);
    end

    // Next-state logic: arbitration in IDLE, address walk in ISSUE.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        rom_ena_d  = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d    = S_ISSUE;
                    owner_d    = pick1;
                    last_d     = pick1;
                    gnt0_d     = ~pick1;
                    gnt1_d     = pick1;
                    cnt_d      = pick1 ? len1 : len0;
                    rom_addr_d = pick1 ? addr1 : addr0;
                    rom_ena_d  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cnt_q == 4'd0) begin
                    // Last word already on the ROM port; rom_addr holds.
                    state_d = S_DRAIN;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                    rom_addr_d = rom_addr_q + 4'd1;
                    rom_ena_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and ROM-port registers; reset wins from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            rom_addr_q <= 4'd0;
            rom_ena_q  <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            rom_ena_q  <= rom_ena_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
        end
    end

    // Read-valid pipeline: mirrors a ROM read issued in the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid0_q <= 1'b0;
            rd_valid1_q <= 1'b0;
        end else begin
            rd_valid0_q <= rom_ena_q & ~owner_q;
            rd_valid1_q <= rom_ena_q & owner_q;
        end
    end

    // Output mapping; done coincides with the last beat, which lands in DRAIN.
    always_comb begin
        gnt0      = gnt0_q;
        gnt1      = gnt1_q;
        busy      = (state_q != S_IDLE);
        rom_addr  = rom_addr_q;
        rom_ena   = rom_ena_q;
        rd_valid0 = rd_valid0_q;
        rd_valid1 = rd_valid1_q;
        rd_data   = rom_data;
        rd_addr   = rom_addr_in;
        done0     = (state_q == S_DRAIN) & ~owner_q;
        done1     = (state_q == S_DRAIN) & owner_q;
    end

endmodule
